fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_pkg.sv | 12 +
 rtl/fifo_rd_stream.sv | 104 ++++++++++
 tb/tb_fifo_rd_stream.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and defaults for the FIFO read-side stream adapter.
package fifo_rd_stream_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      S_EMPTY = 2'b00,
      S_ONE   = 2'b01,
      S_TWO   = 2'b10
   } state_t;

endpackage

// File: rtl/fifo_rd_stream.sv
// Pops an async FIFO read side into a registered valid/ready stream via a 2-entry skid buffer.
// Optional even parity on the output, enabled by defining FIFO_RD_STREAM_PAR_EN.
//
// state   | meaning
// S_EMPTY | no word held, OUT_VALID low
// S_ONE   | HEAD holds a word, SKID free
// S_TWO   | HEAD and SKID both hold words, popping stalled
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  FIFO_EMPTY,
   input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
   output logic                  FIFO_R_INC,
   output logic [DATA_WIDTH-1:0] OUT_DATA,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY
`ifdef FIFO_RD_STREAM_PAR_EN
   ,
   output logic                  OUT_PAR
`endif
);

`ifdef FIFO_RD_STREAM_PAR_EN
   localparam int SW = DATA_WIDTH + 1;
`else
   localparam int SW = DATA_WIDTH;
`endif

   state_t          state_q, state_d;
   logic [SW-1:0]   head_q, head_d;
   logic [SW-1:0]   skid_q, skid_d;
   logic            valid_q, valid_d;
   logic [SW-1:0]   in_word;
   logic            pop;
   logic            accept;

   // Parity travels with the word through HEAD and SKID so it stays aligned.
`ifdef FIFO_RD_STREAM_PAR_EN
   assign in_word = {^FIFO_RD_DATA, FIFO_RD_DATA};
   assign OUT_PAR = head_q[SW-1];
`else
   assign in_word = FIFO_RD_DATA;
`endif

   assign OUT_DATA   = head_q[DATA_WIDTH-1:0];
   assign OUT_VALID  = valid_q;
   assign FIFO_R_INC = pop;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      // RST gates the pop so nothing leaves the FIFO while the buffer is held clear.
      pop     = !RST && !FIFO_EMPTY && (state_q != S_TWO);
      accept  = valid_q && OUT_READY;

      case (state_q)
         S_EMPTY: begin
            if (pop) begin
               head_d  = in_word;
               state_d = S_ONE;
            end
         end
         S_ONE: begin
            if (pop && accept) begin
               head_d = in_word;
            end else if (pop) begin
               skid_d  = in_word;
               state_d = S_TWO;
            end else if (accept) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: begin
            if (accept) begin
               head_d  = skid_q;
               state_d = S_ONE;
            end
         end
         default: state_d = S_EMPTY;
      endcase

      valid_d = (state_d != S_EMPTY);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: per-cycle vector table plus a pop-order scoreboard.
module tb_fifo_rd_stream;

   logic       CLK;
   logic       RST;
   logic       FIFO_EMPTY;
   logic [7:0] FIFO_RD_DATA;
   logic       FIFO_R_INC;
   logic [7:0] OUT_DATA;
   logic       OUT_VALID;
   logic       OUT_READY;
`ifdef FIFO_RD_STREAM_PAR_EN
   logic       OUT_PAR;
`endif

   fifo_rd_stream #(.DATA_WIDTH(8)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .FIFO_EMPTY   (FIFO_EMPTY),
      .FIFO_RD_DATA (FIFO_RD_DATA),
      .FIFO_R_INC   (FIFO_R_INC),
      .OUT_DATA     (OUT_DATA),
      .OUT_VALID    (OUT_VALID),
      .OUT_READY    (OUT_READY)
`ifdef FIFO_RD_STREAM_PAR_EN
      ,
      .OUT_PAR      (OUT_PAR)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      int         ld_n;
      logic [7:0] ld_base;
      logic [7:0] ld_step;
      logic       rdy;
      logic       x_rinc;
      logic       x_valid;
      logic [7:0] x_data;
   } vec_t;

   vec_t       vecs[14];
   logic [7:0] fifo[$];
   logic [7:0] sb[$];
   int         checks = 0;
   int         errors = 0;
   int         pops   = 0;
   logic       rst_v, rdy_v, force_empty;
   logic       s_rinc, s_acc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive_sample();
      @(negedge CLK);
      RST          = rst_v;
      OUT_READY    = rdy_v;
      FIFO_EMPTY   = force_empty || (fifo.size() == 0);
      FIFO_RD_DATA = FIFO_EMPTY ? 8'hEE : fifo[0];
      #1;
      s_rinc = FIFO_R_INC;
      s_acc  = OUT_VALID && OUT_READY;
   endtask

   task automatic commit();
      logic [7:0] exp;
      if (s_acc) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", {24'h0, OUT_DATA}, 32'hFFFF_FFFF);
         end else begin
            exp = sb.pop_front();
            chk("sb_data", {24'h0, OUT_DATA}, {24'h0, exp});
`ifdef FIFO_RD_STREAM_PAR_EN
            chk("sb_par", {31'h0, OUT_PAR}, {31'h0, ^exp});
`endif
         end
      end
      if (s_rinc) begin
         if (FIFO_EMPTY) begin
            chk("pop_while_empty", 32'h1, 32'h0);
         end else begin
            sb.push_back(fifo.pop_front());
            pops++;
         end
      end
   endtask

   task automatic cycle();
      drive_sample();
      commit();
   endtask

   initial begin
      int p0;
      int prev_force;

      vecs[0]  = '{3, 8'h11, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00};
      vecs[1]  = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11};
      vecs[2]  = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22};
      vecs[3]  = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33};
      vecs[4]  = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[5]  = '{4, 8'hA0, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[6]  = '{0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA0};
      vecs[7]  = '{0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA0};
      vecs[8]  = '{0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA0};
      vecs[9]  = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA0};
      vecs[10] = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA1};
      vecs[11] = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2};
      vecs[12] = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA3};
      vecs[13] = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};

      RST = 1'b1; OUT_READY = 1'b0; FIFO_EMPTY = 1'b1; FIFO_RD_DATA = 8'h00;
      rst_v = 1'b1; rdy_v = 1'b0; force_empty = 1'b0;

      // Reset with data waiting: no pop, outputs cleared.
      fifo.push_back(8'h77);
      for (int i = 0; i < 2; i++) begin
         drive_sample();
         chk("rst_rinc", {31'h0, FIFO_R_INC}, 32'h0);
         chk("rst_valid", {31'h0, OUT_VALID}, 32'h0);
         chk("rst_data", {24'h0, OUT_DATA}, 32'h0);
         commit();
      end
      rst_v = 1'b0;
      drive_sample();
      chk("rel_rinc", {31'h0, FIFO_R_INC}, 32'h1);
      chk("rel_valid", {31'h0, OUT_VALID}, 32'h0);
      commit();
      rdy_v = 1'b1;
      drive_sample();
      chk("rel_first_valid", {31'h0, OUT_VALID}, 32'h1);
      chk("rel_first_data", {24'h0, OUT_DATA}, 32'h77);
      commit();
      cycle();

      // Streaming and backpressure vectors.
      p0 = pops;
      for (int i = 0; i < 14; i++) begin
         if (i == 5) p0 = pops;
         for (int k = 0; k < vecs[i].ld_n; k++)
            fifo.push_back(vecs[i].ld_base + 8'(k) * vecs[i].ld_step);
         rdy_v = vecs[i].rdy;
         drive_sample();
         chk($sformatf("vec%0d_rinc", i), {31'h0, FIFO_R_INC}, {31'h0, vecs[i].x_rinc});
         chk($sformatf("vec%0d_valid", i), {31'h0, OUT_VALID}, {31'h0, vecs[i].x_valid});
         if (vecs[i].x_valid)
            chk($sformatf("vec%0d_data", i), {24'h0, OUT_DATA}, {24'h0, vecs[i].x_data});
         commit();
         if (i == 4) chk("stream_pops", pops - p0, 3);
         if (i == 8) chk("bp_pops", pops - p0, 2);
      end

      // Underflow: FIFO_EMPTY toggles every cycle.
      for (int k = 0; k < 4; k++) fifo.push_back(8'hC0 + 8'(k));
      rdy_v = 1'b1;
      prev_force = 1;
      for (int i = 0; i < 8; i++) begin
         force_empty = i[0];
         drive_sample();
         chk($sformatf("uf%0d_rinc", i), {31'h0, FIFO_R_INC}, {31'h0, !FIFO_EMPTY});
         chk($sformatf("uf%0d_valid", i), {31'h0, OUT_VALID}, (prev_force == 0) ? 32'h1 : 32'h0);
         commit();
         prev_force = force_empty;
      end
      force_empty = 1'b0;
      cycle();

      // Mid-operation reset while holding two words.
      rdy_v = 1'b0;
      fifo.push_back(8'h5A);
      fifo.push_back(8'h5B);
      cycle();
      cycle();
      drive_sample();
      chk("two_rinc", {31'h0, FIFO_R_INC}, 32'h0);
      chk("two_data", {24'h0, OUT_DATA}, 32'h5A);
      commit();
      #2;
      rst_v = 1'b1;
      RST = 1'b1;
      #1;
      chk("async_valid", {31'h0, OUT_VALID}, 32'h0);
      chk("async_data", {24'h0, OUT_DATA}, 32'h0);
      chk("async_rinc", {31'h0, FIFO_R_INC}, 32'h0);
      chk("discarded_cnt", sb.size(), 2);
      sb.delete();
      cycle();
      rst_v = 1'b0;
      rdy_v = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_sample();
         chk($sformatf("post_rst%0d_valid", i), {31'h0, OUT_VALID}, 32'h0);
         commit();
      end
      fifo.push_back(8'h66);
      cycle();
      drive_sample();
      chk("post_rst_data", {24'h0, OUT_DATA}, 32'h66);
      commit();
      cycle();

`ifdef FIFO_RD_STREAM_PAR_EN
      rdy_v = 1'b0;
      fifo.push_back(8'h07);
      fifo.push_back(8'h03);
      cycle();
      cycle();
      drive_sample();
      chk("par07_data", {24'h0, OUT_DATA}, 32'h07);
      chk("par07", {31'h0, OUT_PAR}, 32'h1);
      commit();
      rdy_v = 1'b1;
      cycle();
      drive_sample();
      chk("par03_data", {24'h0, OUT_DATA}, 32'h03);
      chk("par03_skid", {31'h0, OUT_PAR}, 32'h0);
      commit();
`endif

      rdy_v = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (sb.size() != 0 || fifo.size() != 0) cycle();
      end
      chk("drain_sb", sb.size(), 0);
      chk("drain_fifo", fifo.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
